pbs_battle_datapath: RTL and testbench

- Datapath partner of the battle control FSM; holds both Pokemon HP registers and computes damage when the FSM asserts calc_damage.
- Subtracts damage from the selected target when the FSM asserts apply_damage, and reports HP-alive status back to the FSM.
- Damage is computed by a 4-cycle shift-add multiplier.
- AI move choice comes from a free-running LFSR.

---
 rtl/pbs_pkg.sv | 28 ++
 rtl/pbs_lfsr8.sv | 22 ++
 rtl/pbs_battle_datapath.sv | 149 ++++++++++++++
 tb/tb_pbs_battle_datapath.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pbs_pkg.sv
// rtl/pbs_pkg.sv - shared battle encodings and move power table
package pbs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } dp_state_t;

    // Used for both active_trainer and target, shared with the control FSM.
    typedef enum logic {
        PLAYER = 1'b0,
        AI     = 1'b1
    } trainer_t;

    localparam int PWR_W = 6;
    localparam int ATK_W = 4;

    function automatic logic [PWR_W-1:0] move_power(input logic [1:0] move);
        case (move)
            2'd0:    return 6'd8;
            2'd1:    return 6'd12;
            2'd2:    return 6'd16;
            default: return 6'd40;
        endcase
    endfunction

endpackage

// File: rtl/pbs_lfsr8.sv
// rtl/pbs_lfsr8.sv - free-running seedable 8-bit Fibonacci LFSR (taps 8,6,5,4)
module pbs_lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic [1:0] move_bits
);

    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign move_bits = lfsr[1:0];

endmodule

// File: rtl/pbs_battle_datapath.sv
// rtl/pbs_battle_datapath.sv - HP registers and shift-add damage calculator
module pbs_battle_datapath
    import pbs_pkg::*;
#(
    parameter int         HP_W      = 8,
    parameter int         MAX_HP    = 100,
    parameter int         P_ATK     = 6,
    parameter int         AI_ATK    = 5,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            new_game,
    input  logic [1:0]      p_move,
    input  logic            calc_damage,
    input  logic            active_trainer,
    input  logic            apply_damage,
    input  logic            target,
    output logic [HP_W-1:0] p_hp,
    output logic [HP_W-1:0] ai_hp,
    output logic            p_alive,
    output logic            ai_alive,
    output logic [HP_W-1:0] damage,
    output logic            dmg_valid,
    output logic [1:0]      ai_move
);

    localparam int ACC_W = 10;
    localparam logic [ACC_W-1:0] DMG_MAX = ACC_W'((1 << HP_W) - 1);

    dp_state_t        state, state_nxt;
    logic             attacker, attacker_nxt;
    logic [PWR_W-1:0] mcand, mcand_nxt;
    logic [ATK_W-1:0] mplier, mplier_nxt;
    logic [ACC_W-1:0] acc, acc_nxt, add_term, acc_sum, scaled;
    logic [1:0]       cnt, cnt_nxt, ai_move_nxt, move_sel, lfsr_bits;
    logic [HP_W-1:0]  p_hp_nxt, ai_hp_nxt, damage_nxt;
    logic             dmg_valid_nxt, start;

    pbs_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk       (clk),
        .reset_n   (reset_n),
        .move_bits (lfsr_bits)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            attacker  <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            p_hp      <= HP_W'(MAX_HP);
            ai_hp     <= HP_W'(MAX_HP);
            damage    <= '0;
            dmg_valid <= 1'b0;
            ai_move   <= '0;
        end else begin
            state     <= state_nxt;
            attacker  <= attacker_nxt;
            mcand     <= mcand_nxt;
            mplier    <= mplier_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            p_hp      <= p_hp_nxt;
            ai_hp     <= ai_hp_nxt;
            damage    <= damage_nxt;
            dmg_valid <= dmg_valid_nxt;
            ai_move   <= ai_move_nxt;
        end
    end

    // One partial product per MUL cycle; the final sum is scaled by 1/4.
    always_comb begin
        add_term = mplier[cnt] ? (ACC_W'(mcand) << cnt) : '0;
        acc_sum  = acc + add_term;
        scaled   = acc_sum >> 2;
    end

    always_comb begin
        state_nxt     = state;
        attacker_nxt  = attacker;
        mcand_nxt     = mcand;
        mplier_nxt    = mplier;
        acc_nxt       = acc;
        cnt_nxt       = cnt;
        p_hp_nxt      = p_hp;
        ai_hp_nxt     = ai_hp;
        damage_nxt    = damage;
        dmg_valid_nxt = dmg_valid;
        ai_move_nxt   = ai_move;
        move_sel      = p_move;
        start         = 1'b0;

        if (new_game) begin
            p_hp_nxt      = HP_W'(MAX_HP);
            ai_hp_nxt     = HP_W'(MAX_HP);
            dmg_valid_nxt = 1'b0;
            state_nxt     = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: start = calc_damage;
                ST_MUL: begin
                    acc_nxt = acc_sum;
                    cnt_nxt = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        damage_nxt    = (scaled > DMG_MAX) ? '1 : HP_W'(scaled);
                        dmg_valid_nxt = 1'b1;
                        state_nxt     = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (apply_damage && dmg_valid) begin
                        if (target == AI) begin
                            ai_hp_nxt = (ai_hp > damage) ? ai_hp - damage : '0;
                        end else begin
                            p_hp_nxt = (p_hp > damage) ? p_hp - damage : '0;
                        end
                        dmg_valid_nxt = 1'b0;
                        state_nxt     = ST_IDLE;
                    end else if (calc_damage && (active_trainer != attacker)) begin
                        // Attacker switched: drop the stale result and restart now.
                        dmg_valid_nxt = 1'b0;
                        start         = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase

            if (start) begin
                attacker_nxt = active_trainer;
                if (active_trainer == AI) begin
                    move_sel    = lfsr_bits;
                    ai_move_nxt = lfsr_bits;
                end
                mcand_nxt  = move_power(move_sel);
                mplier_nxt = (active_trainer == AI) ? ATK_W'(AI_ATK) : ATK_W'(P_ATK);
                acc_nxt    = '0;
                cnt_nxt    = '0;
                state_nxt  = ST_MUL;
            end
        end
    end

    assign p_alive  = |p_hp;
    assign ai_alive = |ai_hp;

endmodule

// File: tb/tb_pbs_battle_datapath.sv
// tb/tb_pbs_battle_datapath.sv - directed plus randomized bench with reference model
module tb_pbs_battle_datapath;

    localparam logic [7:0] SEED = 8'hA5;

    logic       clk = 1'b0;
    logic       reset_n, new_game, calc_damage, active_trainer, apply_damage, target;
    logic [1:0] p_move;
    logic [7:0] p_hp, ai_hp, damage;
    logic       p_alive, ai_alive, dmg_valid;
    logic [1:0] ai_move;

    int         vectors = 0;
    int         miscompares = 0;
    int         power_tbl [4] = '{8, 12, 16, 40};
    int         m_p_hp, m_ai_hp, m_damage, m_ai_move;
    logic [7:0] m_lfsr;

    pbs_battle_datapath dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .new_game       (new_game),
        .p_move         (p_move),
        .calc_damage    (calc_damage),
        .active_trainer (active_trainer),
        .apply_damage   (apply_damage),
        .target         (target),
        .p_hp           (p_hp),
        .ai_hp          (ai_hp),
        .p_alive        (p_alive),
        .ai_alive       (ai_alive),
        .damage         (damage),
        .dmg_valid      (dmg_valid),
        .ai_move        (ai_move)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        logic fb;
        fb = s[8-1] ^ s[6-1] ^ s[5-1] ^ s[4-1];
        return {s[6:0], fb};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m_lfsr = reset_n ? lfsr_step(m_lfsr) : SEED;
    endtask

    task automatic chk_hp(input string tag);
        chk({tag, "_p_hp"}, p_hp, m_p_hp);
        chk({tag, "_ai_hp"}, ai_hp, m_ai_hp);
        chk({tag, "_p_alive"}, p_alive, m_p_hp != 0);
        chk({tag, "_ai_alive"}, ai_alive, m_ai_hp != 0);
    endtask

    task automatic do_calc(input logic tr, input logic [1:0] mv);
        int mv_used, atk;
        calc_damage    = 1'b1;
        active_trainer = tr;
        p_move         = mv;
        mv_used        = tr ? int'(m_lfsr[1:0]) : int'(mv);
        atk            = tr ? 5 : 6;
        tick();
        if (tr) m_ai_move = mv_used;
        for (int i = 1; i <= 4; i++) begin
            chk("dmg_valid_busy", dmg_valid, 0);
            tick();
        end
        m_damage = (power_tbl[mv_used] * atk) / 4;
        if (m_damage > 255) m_damage = 255;
        chk("dmg_valid_edge5", dmg_valid, 1);
        chk("damage", damage, m_damage);
        chk("ai_move", ai_move, m_ai_move);
        chk_hp("calc");
        tick();
        chk("dmg_hold_valid", dmg_valid, 1);
        chk("dmg_hold_value", damage, m_damage);
        calc_damage = 1'b0;
    endtask

    task automatic do_apply(input logic tg);
        apply_damage = 1'b1;
        target       = tg;
        tick();
        if (tg) m_ai_hp = (m_ai_hp > m_damage) ? m_ai_hp - m_damage : 0;
        else    m_p_hp  = (m_p_hp > m_damage) ? m_p_hp - m_damage : 0;
        chk_hp("apply");
        chk("apply_valid_clr", dmg_valid, 0);
        apply_damage = 1'b0;
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        m_p_hp   = 100;
        m_ai_hp  = 100;
        chk_hp("new_game");
        chk("new_game_valid", dmg_valid, 0);
    endtask

    initial begin
        reset_n = 1'b0; new_game = 1'b0; p_move = 2'd0; calc_damage = 1'b0;
        active_trainer = 1'b0; apply_damage = 1'b0; target = 1'b0;
        m_lfsr = SEED; m_p_hp = 100; m_ai_hp = 100; m_damage = 0; m_ai_move = 0;
        tick();
        tick();
        chk_hp("reset");
        chk("reset_damage", damage, 0);
        chk("reset_valid", dmg_valid, 0);
        chk("reset_ai_move", ai_move, 0);
        reset_n = 1'b1;

        // Player move 2 against the AI: 16*6/4 = 24, 100 -> 76.
        do_calc(1'b0, 2'd2);
        chk("player_dmg_24", damage, 24);
        do_apply(1'b1);
        chk("ai_hp_76", ai_hp, 76);

        apply_damage = 1'b1;
        target = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("apply_held_ai_hp", ai_hp, 76);
        end
        apply_damage = 1'b0;

        do_calc(1'b1, 2'd0);
        do_apply(1'b0);

        // Move 3 saturates the AI to zero and stays there.
        do_new_game();
        for (int i = 0; i < 3; i++) begin
            do_calc(1'b0, 2'd3);
            chk("move3_dmg_60", damage, 60);
            do_apply(1'b1);
        end
        chk("ai_hp_zero", ai_hp, 0);
        chk("ai_dead", ai_alive, 0);

        do_new_game();
        do_calc(1'b0, 2'd1);
        do_calc(1'b1, 2'd0);
        do_apply(1'b0);

        for (int r = 0; r < 16; r++) begin
            logic tr_r, tg_r;
            logic [1:0] mv_r;
            tr_r = 1'($urandom_range(0, 1));
            tg_r = 1'($urandom_range(0, 1));
            mv_r = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) do_new_game();
            do_calc(tr_r, mv_r);
            do_apply(tg_r);
        end

        // Asynchronous reset during MUL aborts the calculation.
        calc_damage = 1'b1;
        active_trainer = 1'b0;
        p_move = 2'd3;
        tick();
        reset_n = 1'b0;
        #1;
        m_lfsr = SEED; m_p_hp = 100; m_ai_hp = 100; m_damage = 0; m_ai_move = 0;
        chk_hp("mid_reset");
        chk("mid_reset_valid", dmg_valid, 0);
        chk("mid_reset_damage", damage, 0);
        chk("mid_reset_ai_move", ai_move, 0);
        calc_damage = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_reset_valid", dmg_valid, 0);
        chk_hp("post_reset");

        do_calc(1'b1, 2'd2);
        do_apply(1'b0);
        do_calc(1'b0, 2'd3);
        do_apply(1'b1);
        do_calc(1'b0, 2'd1);
        do_new_game();
        do_calc(1'b0, 2'd0);
        do_apply(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
